// File: rtl/function_pipe_pkg.sv
`default_nettype none
// ============================================================================
// function_pipe_pkg : mode encoding and per-bit combine function for function_pipe_nbit
// Revision: 1.0
// ============================================================================
package function_pipe_pkg;

  typedef enum logic [1:0] {
    MODE_XOR  = 2'b00,
    MODE_XNOR = 2'b01,
    MODE_MAJ  = 2'b10,
    MODE_AND  = 2'b11
  } mode_e;

  function automatic logic f_combine(input logic part1, input logic part2,
                                     input logic gh, input mode_e mode);
    logic r;
    case (mode)
      MODE_XOR:  r = part1 ^ part2 ^ gh;
      MODE_XNOR: r = ~(part1 ^ part2 ^ gh);
      MODE_MAJ:  r = (part1 & part2) | (part1 & gh) | (part2 & gh);
      MODE_AND:  r = part1 & part2 & gh;
      default:   r = 1'b0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_pipe_reg.sv
`default_nettype none
// ============================================================================
// fp_pipe_reg : single valid/ready register slice, W-bit payload, no skid buffer
// Revision: 1.0
// ============================================================================
module fp_pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  // Loading is allowed when empty or when the held item leaves this cycle.
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      out_data  <= in_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/function_pipe_nbit.sv
`default_nettype none
// ============================================================================
// function_pipe_nbit : 2-stage pipelined y = ((a&b)|c)^((d&e)|f)^(g&h) with mode select
// Optional y_par output enabled by macro FUNCTION_PIPE_PARITY_EN.  Revision: 1.0
// ============================================================================
module function_pipe_nbit
  import function_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] e,
  input  logic [WIDTH-1:0] f,
  input  logic [WIDTH-1:0] g,
  input  logic [WIDTH-1:0] h,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
`ifdef FUNCTION_PIPE_PARITY_EN
  output logic             y_par,
`endif
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] res_cnt
);

  localparam int S1_W = 3 * WIDTH + 2;
`ifdef FUNCTION_PIPE_PARITY_EN
  localparam int S2_W = WIDTH + 1;
`else
  localparam int S2_W = WIDTH;
`endif

  logic [S1_W-1:0]  s1_in;
  logic [S1_W-1:0]  s1_out;
  logic             s1_valid;
  logic             s2_ready;
  logic [WIDTH-1:0] s1_p1;
  logic [WIDTH-1:0] s1_p2;
  logic [WIDTH-1:0] s1_gh;
  mode_e            s1_mode;
  logic [WIDTH-1:0] y_next;
  logic [S2_W-1:0]  s2_in;
  logic [S2_W-1:0]  s2_out;

  assign s1_in = {(a & b) | c, (d & e) | f, g & h, mode};

  fp_pipe_reg #(.W(S1_W)) u_stage1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (s1_in),
    .out_valid (s1_valid),
    .out_ready (s2_ready),
    .out_data  (s1_out)
  );

  assign s1_p1   = s1_out[S1_W-1 -: WIDTH];
  assign s1_p2   = s1_out[2*WIDTH+1 -: WIDTH];
  assign s1_gh   = s1_out[WIDTH+1 -: WIDTH];
  assign s1_mode = mode_e'(s1_out[1:0]);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign y_next[i] = f_combine(s1_p1[i], s1_p2[i], s1_gh[i], s1_mode);
  end

`ifdef FUNCTION_PIPE_PARITY_EN
  assign s2_in = {^y_next, y_next};
  assign y_par = s2_out[WIDTH];
`else
  assign s2_in = y_next;
`endif
  assign y = s2_out[WIDTH-1:0];

  fp_pipe_reg #(.W(S2_W)) u_stage2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s1_valid),
    .in_ready  (s2_ready),
    .in_data   (s2_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_out)
  );

  // Clear wins over a coincident output transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_cnt <= '0;
    end else if (cnt_clr) begin
      res_cnt <= '0;
    end else if (out_valid && out_ready) begin
      res_cnt <= res_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_function_pipe_nbit.sv
`default_nettype none
// ============================================================================
// tb_function_pipe_nbit : directed vector table plus stall/counter/reset sequences
// Revision: 1.0
// ============================================================================
module tb_function_pipe_nbit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready, cnt_clr;
  logic [7:0] a, b, c, d, e, f, g, h, y;
  logic [1:0] mode;
  logic [3:0] res_cnt;
`ifdef FUNCTION_PIPE_PARITY_EN
  logic       y_par;
`endif

  function_pipe_nbit #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready), .y(y),
`ifdef FUNCTION_PIPE_PARITY_EN
    .y_par(y_par),
`endif
    .cnt_clr(cnt_clr), .res_cnt(res_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a, b, c, d, e, f, g, h;
    logic [1:0] mode;
    logic [7:0] y;
  } vec_t;

  vec_t       vecs[9];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] exp_cnt = 4'd0;
  logic [7:0] seq = 8'h10;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive_ops(input vec_t v);
    a = v.a; b = v.b; c = v.c; d = v.d; e = v.e; f = v.f; g = v.g; h = v.h;
    mode = v.mode;
  endtask

  // One isolated transfer: called at a negedge, returns at a negedge.
  task automatic apply_vec(input vec_t v);
    drive_ops(v);
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("lat_early_valid", out_valid, 1'b0);
    @(negedge clk);
    chk("vec_valid", out_valid, 1'b1);
    chk("vec_y", y, v.y);
`ifdef FUNCTION_PIPE_PARITY_EN
    chk("vec_par", y_par, ^v.y);
`endif
    exp_cnt++;
    @(negedge clk);
    chk("vec_one_cycle", out_valid, 1'b0);
    chk("vec_cnt", res_cnt, exp_cnt);
  endtask

  // Streams n sets back-to-back; out_ready low for stream cycles st_lo..st_hi.
  task automatic run_stream(input int n, input int st_lo, input int st_hi);
    int         sent = 0, got = 0, occ = 0, cyc = 0;
    logic [7:0] q[$];
    logic       held = 1'b0;
    logic [7:0] held_y = 8'h00;
    logic [7:0] exp_y;
    while (got < n && cyc < 200) begin
      out_ready = !(cyc >= st_lo && cyc <= st_hi);
      in_valid  = (sent < n);
      a = seq; b = 8'hFF; c = 8'h00; d = 8'h00; e = 8'h00; f = 8'h00;
      g = 8'h00; h = 8'h00; mode = 2'b00;
      #1;
      chk("stream_in_ready", in_ready, (occ < 2) || out_ready);
      if (held) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_y", y, held_y);
      end
      if (in_valid && in_ready) begin
        q.push_back(seq);
        seq++; sent++; occ++;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("stream_spurious", out_valid, 1'b0);
        end else begin
          exp_y = q.pop_front();
          chk("stream_order_y", y, exp_y);
        end
        got++; occ--; exp_cnt++;
      end
      held   = out_valid && !out_ready;
      held_y = y;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    if (got < n) chk("stream_timeout_results", got, n);
  endtask

  initial begin
    // Expected y values derived bit-wise from the function definition.
    vecs[0] = '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 8'hFF};
    vecs[1] = '{8'hF0, 8'hCC, 8'h01, 8'hAA, 8'hAA, 8'h00, 8'h0F, 8'h0F, 2'b00, 8'h64};
    vecs[2] = '{8'hF0, 8'hCC, 8'h01, 8'hAA, 8'hAA, 8'h00, 8'h0F, 8'h0F, 2'b01, 8'h9B};
    vecs[3] = '{8'hF0, 8'hCC, 8'h01, 8'hAA, 8'hAA, 8'h00, 8'h0F, 8'h0F, 2'b11, 8'h00};
    vecs[4] = '{8'hF0, 8'hCC, 8'h01, 8'hAA, 8'hAA, 8'h00, 8'h0F, 8'h0F, 2'b10, 8'h8B};
    vecs[5] = '{8'h00, 8'h00, 8'h0F, 8'h00, 8'h00, 8'h33, 8'h55, 8'h55, 2'b00, 8'h69};
    vecs[6] = '{8'h00, 8'h00, 8'h0F, 8'h00, 8'h00, 8'h33, 8'h55, 8'h55, 2'b10, 8'h17};
    vecs[7] = '{8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b10, 8'h00};
    vecs[8] = '{8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 2'b11, 8'hFF};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
    drive_ops(vecs[0]);
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_y", y, 8'h00);
    chk("rst_cnt", res_cnt, 4'd0);
`ifdef FUNCTION_PIPE_PARITY_EN
    chk("rst_par", y_par, 1'b0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1'b1);

    for (int i = 0; i < 9; i++) apply_vec(vecs[i]);

    run_stream(5, 3, 6);
    chk("bp_cnt", res_cnt, exp_cnt);

    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0; exp_cnt = 4'd0;
    chk("clr_idle", res_cnt, 4'd0);

    run_stream(16, 1000, 1000);
    chk("cnt_wrap", res_cnt, 4'd0);
    run_stream(3, 1000, 1000);
    chk("cnt_three", res_cnt, 4'd3);

    drive_ops(vecs[0]);
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("clr_xfer_valid", out_valid, 1'b1);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0; exp_cnt = 4'd0;
    chk("clr_with_xfer", res_cnt, 4'd0);
    chk("clr_xfer_consumed", out_valid, 1'b0);

    run_stream(2, 1000, 1000);
    chk("pre_rst_cnt", res_cnt, 4'd2);
    drive_ops(vecs[1]);
    in_valid = 1'b1; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("full_in_ready", in_ready, 1'b0);
    chk("full_out_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 1'b0);
    chk("async_rst_y", y, 8'h00);
    chk("async_rst_cnt", res_cnt, 4'd0);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1; exp_cnt = 4'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_stale_valid", out_valid, 1'b0);
    end
    apply_vec(vecs[5]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
